// File: rtl/text_pkg.sv
// text_pkg: shared glyph geometry, character codes and blitter state encoding.
package text_pkg;
    localparam int GLYPH_W    = 5;
    localparam int GLYPH_H    = 7;
    localparam int CODE_W     = 5;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

    localparam logic [CODE_W-1:0] CH_SPACE = 5'd0;
    localparam logic [CODE_W-1:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4,  CH_E = 5'd5;
    localparam logic [CODE_W-1:0] CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8,  CH_I = 5'd9,  CH_J = 5'd10;
    localparam logic [CODE_W-1:0] CH_K = 5'd11, CH_L = 5'd12, CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15;
    localparam logic [CODE_W-1:0] CH_P = 5'd16, CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
    localparam logic [CODE_W-1:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24, CH_Y = 5'd25;
    localparam logic [CODE_W-1:0] CH_Z = 5'd26;

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    // Bitmap art is written row by row with the top-left pixel as the leftmost digit.
    function automatic logic [GLYPH_BITS-1:0] rows(input logic [GLYPH_BITS-1:0] art);
        logic [GLYPH_BITS-1:0] r;
        for (int i = 0; i < GLYPH_BITS; i++) r[i] = art[GLYPH_BITS-1-i];
        return r;
    endfunction
endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational 5x7 font; bit py*GLYPH_W+px is the pixel, unknown codes are blank.
module glyph_rom
    import text_pkg::*;
(
    input  logic [CODE_W-1:0]     code,
    output logic [GLYPH_BITS-1:0] bits
);
    always_comb begin
        case (code)
            CH_A:    bits = rows(35'b01110_10001_10001_11111_10001_10001_10001);
            CH_B:    bits = rows(35'b11110_10001_10001_11110_10001_10001_11110);
            CH_C:    bits = rows(35'b01110_10001_10000_10000_10000_10001_01110);
            CH_D:    bits = rows(35'b11110_10001_10001_10001_10001_10001_11110);
            CH_E:    bits = rows(35'b11111_10000_10000_11110_10000_10000_11111);
            CH_F:    bits = rows(35'b11111_10000_10000_11110_10000_10000_10000);
            CH_G:    bits = rows(35'b01110_10001_10000_10111_10001_10001_01111);
            CH_H:    bits = rows(35'b10001_10001_10001_11111_10001_10001_10001);
            CH_I:    bits = rows(35'b01110_00100_00100_00100_00100_00100_01110);
            CH_J:    bits = rows(35'b00111_00010_00010_00010_00010_10010_01100);
            CH_K:    bits = rows(35'b10001_10010_10100_11000_10100_10010_10001);
            CH_L:    bits = rows(35'b10000_10000_10000_10000_10000_10000_11111);
            CH_M:    bits = rows(35'b10001_11011_10101_10101_10001_10001_10001);
            CH_N:    bits = rows(35'b10001_10001_11001_10101_10011_10001_10001);
            CH_O:    bits = rows(35'b01110_10001_10001_10001_10001_10001_01110);
            CH_P:    bits = rows(35'b11110_10001_10001_11110_10000_10000_10000);
            CH_Q:    bits = rows(35'b01110_10001_10001_10001_10101_10010_01101);
            CH_R:    bits = rows(35'b11110_10001_10001_11110_10100_10010_10001);
            CH_S:    bits = rows(35'b01111_10000_10000_01110_00001_00001_11110);
            CH_T:    bits = rows(35'b11111_00100_00100_00100_00100_00100_00100);
            CH_U:    bits = rows(35'b10001_10001_10001_10001_10001_10001_01110);
            CH_V:    bits = rows(35'b10001_10001_10001_10001_10001_01010_00100);
            CH_W:    bits = rows(35'b10001_10001_10001_10101_10101_10101_01010);
            CH_X:    bits = rows(35'b10001_10001_01010_00100_01010_10001_10001);
            CH_Y:    bits = rows(35'b10001_10001_01010_00100_00100_00100_00100);
            CH_Z:    bits = rows(35'b11111_00001_00010_00100_01000_10000_11111);
            default: bits = '0;
        endcase
    end
endmodule

// File: rtl/text_blitter.sv
// text_blitter: streams a grid of 5x7 glyphs as one registered pixel per accepted cycle,
// with latched origin/colours/string, optional transparent background and ready back-pressure.
module text_blitter
    import text_pkg::*;
#(
    parameter int NUM_CHARS     = 8,
    parameter int CHARS_PER_ROW = 4,
    parameter int CHAR_PITCH_X  = 8,
    parameter int LINE_PITCH_Y  = 11,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int COLOR_W       = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [X_W-1:0]              x_origin,
    input  logic [Y_W-1:0]              y_origin,
    input  logic [COLOR_W-1:0]          fg_color,
    input  logic [COLOR_W-1:0]          bg_color,
    input  logic                        transparent,
    input  logic [NUM_CHARS*CODE_W-1:0] char_codes,
    input  logic                        ready,
    output logic                        plot,
    output logic [X_W-1:0]              x,
    output logic [Y_W-1:0]              y,
    output logic [COLOR_W-1:0]          color,
    output logic                        busy,
    output logic                        done
);
    localparam int CH_W  = NUM_CHARS > 1 ? $clog2(NUM_CHARS) : 1;
    localparam int COL_W = CHARS_PER_ROW > 1 ? $clog2(CHARS_PER_ROW) : 1;

    state_t                      state_q, state_d;
    logic [2:0]                  px_q, px_d, py_q, py_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [COL_W-1:0]            gcol_q, gcol_d;
    logic [X_W-1:0]              xo_q, xo_d, xb_q, xb_d, x_q, x_d;
    logic [Y_W-1:0]              yb_q, yb_d, y_q, y_d;
    logic [COLOR_W-1:0]          fg_q, fg_d, bg_q, bg_d, color_q, color_d;
    logic                        trans_q, trans_d, plot_q, plot_d;
    logic [NUM_CHARS*CODE_W-1:0] codes_q, codes_d;
    logic [CODE_W-1:0]           code;
    logic [GLYPH_BITS-1:0]       bits;
    logic [5:0]                  idx;
    logic                        advance, last, load, bit_on;

    assign advance = state_q == S_DRAW && (!plot_q || ready);
    assign last    = ch_q == CH_W'(NUM_CHARS-1) && py_q == 3'(GLYPH_H-1) && px_q == 3'(GLYPH_W-1);
    assign load    = (state_q == S_IDLE && start) || (advance && !last);

    // Scan position of the next pixel; xb/yb hold the running top-left of the current glyph.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        ch_d    = ch_q;
        gcol_d  = gcol_q;
        xo_d    = xo_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        trans_d = trans_q;
        codes_d = codes_q;
        if (state_q == S_IDLE && start) begin
            state_d = S_DRAW;
            px_d    = '0;
            py_d    = '0;
            ch_d    = '0;
            gcol_d  = '0;
            xo_d    = x_origin;
            xb_d    = x_origin;
            yb_d    = y_origin;
            fg_d    = fg_color;
            bg_d    = bg_color;
            trans_d = transparent;
            codes_d = char_codes;
        end else if (advance) begin
            if (last) state_d = S_DONE;
            else if (px_q != 3'(GLYPH_W-1)) px_d = px_q + 3'd1;
            else begin
                px_d = '0;
                if (py_q != 3'(GLYPH_H-1)) py_d = py_q + 3'd1;
                else begin
                    py_d = '0;
                    ch_d = ch_q + 1'b1;
                    if (gcol_q != COL_W'(CHARS_PER_ROW-1)) begin
                        gcol_d = gcol_q + 1'b1;
                        xb_d   = xb_q + X_W'(CHAR_PITCH_X);
                    end else begin
                        gcol_d = '0;
                        xb_d   = xo_q;
                        yb_d   = yb_q + Y_W'(LINE_PITCH_Y);
                    end
                end
            end
        end else if (state_q == S_DONE) state_d = S_IDLE;
    end

    assign code   = codes_d[ch_d*CODE_W +: CODE_W];
    assign idx    = 6'(py_d) * 6'(GLYPH_W) + 6'(px_d);
    assign bit_on = bits[idx];

    glyph_rom u_rom (
        .code (code),
        .bits (bits)
    );

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        plot_d  = plot_q;
        if (load) begin
            x_d     = xb_d + X_W'(px_d);
            y_d     = yb_d + Y_W'(py_d);
            color_d = bit_on ? fg_d : bg_d;
            plot_d  = bit_on || !trans_d;
        end else if (advance) plot_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            ch_q    <= '0;
            gcol_q  <= '0;
            xo_q    <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            trans_q <= 1'b0;
            codes_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ch_q    <= ch_d;
            gcol_q  <= gcol_d;
            xo_q    <= xo_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            trans_q <= trans_d;
            codes_q <= codes_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
        end
    end

    assign plot  = plot_q;
    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign busy  = state_q == S_DRAW;
    assign done  = state_q == S_DONE;
endmodule
